// File: rtl/issue_sb_pkg.sv
// Shared types and constants for the dual-issue result-latency scoreboard.
package issue_sb_pkg;

    localparam int LAT_W = 3;
    localparam int NREG  = 32;

    typedef logic [LAT_W-1:0] lat_t;
    typedef logic [4:0]       reg_idx_t;

    localparam lat_t     LAT_INF  = '1;
    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/sb_hazard_chk.sv
// Source-operand hazard detect: flags a read of a register whose result is not yet forwardable.
module sb_hazard_chk
    import issue_sb_pkg::*;
(
    input  lat_t     cnt [NREG],
    input  reg_idx_t rs,
    input  reg_idx_t rt,
    input  logic     rs_en,
    input  logic     rt_en,
    output logic     hazard
);

    always_comb begin
        hazard = (rs_en && (rs != REG_ZERO) && (cnt[rs] != '0)) ||
                 (rt_en && (rt != REG_ZERO) && (cnt[rt] != '0));
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Per-register latency scoreboard deciding master/slave issue in the dual-issue stage.
// Optional stall statistics counters are enabled with the macro ISSUE_SB_STATS_EN.
module issue_scoreboard
    import issue_sb_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    input  logic     adv,
    input  logic     flush,
    input  logic     m_valid,
    input  reg_idx_t m_rs,
    input  reg_idx_t m_rt,
    input  logic     m_rs_en,
    input  logic     m_rt_en,
    input  logic     m_wen,
    input  reg_idx_t m_rd,
    input  lat_t     m_lat,
    input  logic     s_valid,
    input  reg_idx_t s_rs,
    input  reg_idx_t s_rt,
    input  logic     s_rs_en,
    input  logic     s_rt_en,
    input  logic     s_wen,
    input  reg_idx_t s_rd,
    input  lat_t     s_lat,
    input  logic     wb_clr,
    input  reg_idx_t wb_clr_addr,
    output logic     m_issue,
    output logic     s_issue,
    output logic     stall,
    output logic     busy
`ifdef ISSUE_SB_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] slave_block_cycles
`endif
);

    lat_t cnt_q [NREG];
    lat_t cnt_d [NREG];
    logic m_haz;
    logic s_haz;
    logic pair_raw;
    logic pair_waw;

    sb_hazard_chk u_m_haz (
        .cnt    (cnt_q),
        .rs     (m_rs),
        .rt     (m_rt),
        .rs_en  (m_rs_en),
        .rt_en  (m_rt_en),
        .hazard (m_haz)
    );

    sb_hazard_chk u_s_haz (
        .cnt    (cnt_q),
        .rs     (s_rs),
        .rt     (s_rt),
        .rs_en  (s_rs_en),
        .rt_en  (s_rt_en),
        .hazard (s_haz)
    );

    always_comb begin
        pair_raw = m_wen && (m_rd != REG_ZERO) &&
                   ((s_rs_en && (s_rs == m_rd)) || (s_rt_en && (s_rt == m_rd)));
        pair_waw = m_wen && s_wen && (s_rd == m_rd) && (m_rd != REG_ZERO);
        m_issue  = adv && !flush && m_valid && !m_haz;
        s_issue  = m_issue && s_valid && !s_haz && !pair_raw && !pair_waw;
        stall    = m_valid && !m_issue;
    end

    // Later assignments win: flush > slave write > master write > wb_clr > decrement.
    always_comb begin
        busy     = 1'b0;
        cnt_d[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (adv && (cnt_q[i] != '0) && (cnt_q[i] != LAT_INF)) begin
                cnt_d[i] = cnt_q[i] - lat_t'(1);
            end
            if (wb_clr && (wb_clr_addr == reg_idx_t'(i))) begin
                cnt_d[i] = '0;
            end
            if (m_issue && m_wen && (m_rd == reg_idx_t'(i))) begin
                cnt_d[i] = m_lat;
            end
            if (s_issue && s_wen && (s_rd == reg_idx_t'(i))) begin
                cnt_d[i] = s_lat;
            end
            if (flush) begin
                cnt_d[i] = '0;
            end
            busy = busy | (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef ISSUE_SB_STATS_EN
    // Saturating event counters; deliberately survive flush.
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] slave_block_cycles_q;
    logic [31:0] slave_block_cycles_d;

    always_comb begin
        stall_cycles_d       = stall_cycles_q;
        slave_block_cycles_d = slave_block_cycles_q;
        if (stall && adv && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (m_issue && s_valid && !s_issue && (slave_block_cycles_q != 32'hFFFF_FFFF)) begin
            slave_block_cycles_d = slave_block_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles_q       <= '0;
            slave_block_cycles_q <= '0;
        end else begin
            stall_cycles_q       <= stall_cycles_d;
            slave_block_cycles_q <= slave_block_cycles_d;
        end
    end

    assign stall_cycles       = stall_cycles_q;
    assign slave_block_cycles = slave_block_cycles_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard; stats checks need ISSUE_SB_STATS_EN.
module tb_issue_scoreboard;

    logic       clk;
    logic       resetn;
    logic       adv;
    logic       flush;
    logic       m_valid;
    logic [4:0] m_rs;
    logic [4:0] m_rt;
    logic       m_rs_en;
    logic       m_rt_en;
    logic       m_wen;
    logic [4:0] m_rd;
    logic [2:0] m_lat;
    logic       s_valid;
    logic [4:0] s_rs;
    logic [4:0] s_rt;
    logic       s_rs_en;
    logic       s_rt_en;
    logic       s_wen;
    logic [4:0] s_rd;
    logic [2:0] s_lat;
    logic       wb_clr;
    logic [4:0] wb_clr_addr;
    logic       m_issue;
    logic       s_issue;
    logic       stall;
    logic       busy;
`ifdef ISSUE_SB_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] slave_block_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    issue_scoreboard dut (
        .clk         (clk),
        .resetn      (resetn),
        .adv         (adv),
        .flush       (flush),
        .m_valid     (m_valid),
        .m_rs        (m_rs),
        .m_rt        (m_rt),
        .m_rs_en     (m_rs_en),
        .m_rt_en     (m_rt_en),
        .m_wen       (m_wen),
        .m_rd        (m_rd),
        .m_lat       (m_lat),
        .s_valid     (s_valid),
        .s_rs        (s_rs),
        .s_rt        (s_rt),
        .s_rs_en     (s_rs_en),
        .s_rt_en     (s_rt_en),
        .s_wen       (s_wen),
        .s_rd        (s_rd),
        .s_lat       (s_lat),
        .wb_clr      (wb_clr),
        .wb_clr_addr (wb_clr_addr),
        .m_issue     (m_issue),
        .s_issue     (s_issue),
        .stall       (stall),
        .busy        (busy)
`ifdef ISSUE_SB_STATS_EN
        ,
        .stall_cycles       (stall_cycles),
        .slave_block_cycles (slave_block_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        adv = 1'b1; flush = 1'b0; wb_clr = 1'b0; wb_clr_addr = 5'd0;
        m_valid = 1'b0; m_rs = 5'd0; m_rt = 5'd0; m_rs_en = 1'b0; m_rt_en = 1'b0;
        m_wen = 1'b0; m_rd = 5'd0; m_lat = 3'd0;
        s_valid = 1'b0; s_rs = 5'd0; s_rt = 5'd0; s_rs_en = 1'b0; s_rt_en = 1'b0;
        s_wen = 1'b0; s_rd = 5'd0; s_lat = 3'd0;
    endtask

    task automatic issue_write(input logic [4:0] rd, input logic [2:0] lat);
        idle();
        m_valid = 1'b1; m_wen = 1'b1; m_rd = rd; m_lat = lat;
        #1;
        n_checks++; if (m_issue !== 1'b1) begin n_fail++; $display("[TB] FAIL setup_issue rd=%0d got=%0b exp=1", rd, m_issue); end
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        adv = 1'b0;
        resetn = 1'b0;
        #12;
        n_checks++; if (m_issue !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_issue got=%0b exp=0", m_issue); end
        n_checks++; if (s_issue !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_s_issue got=%0b exp=0", s_issue); end
        n_checks++; if (stall !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_stall got=%0b exp=0", stall); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
        tick();
        resetn = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_basic_issue();
        idle();
        m_valid = 1'b1; m_rs = 5'd5; m_rs_en = 1'b1;
        #1;
        n_checks++; if (m_issue !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_m_issue got=%0b exp=1", m_issue); end
        n_checks++; if (stall !== 1'b0)   begin n_fail++; $display("[TB] FAIL basic_stall got=%0b exp=0", stall); end
        tick();
        idle();
    endtask

    task automatic test_latency();
        issue_write(5'd8, 3'd2);
        m_valid = 1'b1; m_rs = 5'd8; m_rs_en = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL lat_stall_c1 got=%0b exp=1", stall); end
        n_checks++; if (busy !== 1'b1)  begin n_fail++; $display("[TB] FAIL lat_busy got=%0b exp=1", busy); end
        tick();
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL lat_stall_c2 got=%0b exp=1", stall); end
        tick();
        n_checks++; if (m_issue !== 1'b1) begin n_fail++; $display("[TB] FAIL lat_issue_c3 got=%0b exp=1", m_issue); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("[TB] FAIL lat_busy_done got=%0b exp=0", busy); end
        tick();
        idle();
    endtask

    task automatic test_pair();
        idle();
        m_valid = 1'b1; m_wen = 1'b1; m_rd = 5'd3; m_lat = 3'd1;
        s_valid = 1'b1; s_rs = 5'd3; s_rs_en = 1'b1;
        #1;
        n_checks++; if (m_issue !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_m_issue got=%0b exp=1", m_issue); end
        n_checks++; if (s_issue !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_s_issue got=%0b exp=0", s_issue); end
        s_rs_en = 1'b0; s_wen = 1'b1; s_rd = 5'd3;
        #1;
        n_checks++; if (s_issue !== 1'b0) begin n_fail++; $display("[TB] FAIL waw_s_issue got=%0b exp=0", s_issue); end
        s_rd = 5'd4; s_lat = 3'd0;
        #1;
        n_checks++; if (s_issue !== 1'b1) begin n_fail++; $display("[TB] FAIL pair_ok_s_issue got=%0b exp=1", s_issue); end
        tick();
        // cnt[3]=1 and cnt[4]=0 now
        idle();
        m_valid = 1'b1; s_valid = 1'b1; s_rs = 5'd3; s_rs_en = 1'b1;
        #1;
        n_checks++; if (m_issue !== 1'b1) begin n_fail++; $display("[TB] FAIL shaz_m_issue got=%0b exp=1", m_issue); end
        n_checks++; if (s_issue !== 1'b0) begin n_fail++; $display("[TB] FAIL shaz_s_issue got=%0b exp=0", s_issue); end
        s_rs = 5'd4;
        #1;
        n_checks++; if (s_issue !== 1'b1) begin n_fail++; $display("[TB] FAIL lat0_s_issue got=%0b exp=1", s_issue); end
        m_rt = 5'd3; m_rt_en = 1'b1;
        #1;
        n_checks++; if (s_issue !== 1'b0) begin n_fail++; $display("[TB] FAIL mstall_s_issue got=%0b exp=0", s_issue); end
        n_checks++; if (stall !== 1'b1)   begin n_fail++; $display("[TB] FAIL mstall_stall got=%0b exp=1", stall); end
        idle();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL pair_drain_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_lat_inf();
        int held;
        held = 0;
        issue_write(5'd10, 3'd7);
        m_valid = 1'b1; m_rs = 5'd10; m_rs_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (stall === 1'b1 && busy === 1'b1) held++;
            tick();
        end
        n_checks++; if (held !== 20) begin n_fail++; $display("[TB] FAIL inf_hold cycles_stalled=%0d exp=20", held); end
        wb_clr = 1'b1; wb_clr_addr = 5'd10;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL inf_clr_cycle_stall got=%0b exp=1", stall); end
        tick();
        wb_clr = 1'b0;
        #1;
        n_checks++; if (m_issue !== 1'b1) begin n_fail++; $display("[TB] FAIL inf_resume got=%0b exp=1", m_issue); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("[TB] FAIL inf_busy got=%0b exp=0", busy); end
        tick();
        idle();
    endtask

    task automatic test_freeze_flush();
        issue_write(5'd4, 3'd2);
        adv = 1'b0; m_valid = 1'b1;
        #1;
        n_checks++; if (m_issue !== 1'b0) begin n_fail++; $display("[TB] FAIL noadv_m_issue got=%0b exp=0", m_issue); end
        n_checks++; if (stall !== 1'b1)   begin n_fail++; $display("[TB] FAIL noadv_stall got=%0b exp=1", stall); end
        for (int i = 0; i < 5; i++) tick();
        adv = 1'b1; m_rs = 5'd4; m_rs_en = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL freeze_c1 got=%0b exp=1", stall); end
        tick();
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL freeze_c2 got=%0b exp=1", stall); end
        tick();
        n_checks++; if (m_issue !== 1'b1) begin n_fail++; $display("[TB] FAIL freeze_c3 got=%0b exp=1", m_issue); end
        tick();
        issue_write(5'd12, 3'd5);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_pre_busy got=%0b exp=1", busy); end
        flush = 1'b1; m_valid = 1'b1;
        #1;
        n_checks++; if (m_issue !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_m_issue got=%0b exp=0", m_issue); end
        tick();
        flush = 1'b0; m_rs = 5'd12; m_rs_en = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("[TB] FAIL flush_busy got=%0b exp=0", busy); end
        n_checks++; if (m_issue !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_resume got=%0b exp=1", m_issue); end
        tick();
        issue_write(5'd13, 3'd7);
        adv = 1'b0; wb_clr = 1'b1; wb_clr_addr = 5'd13;
        tick();
        idle();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_noadv_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_r0_and_async_reset();
        issue_write(5'd0, 3'd3);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL r0_busy got=%0b exp=0", busy); end
        issue_write(5'd9, 3'd7);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_pre_busy got=%0b exp=1", busy); end
        resetn = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy got=%0b exp=0", busy); end
        tick();
        resetn = 1'b1;
        m_valid = 1'b1; m_rs = 5'd9; m_rs_en = 1'b1;
        #1;
        n_checks++; if (m_issue !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_issue got=%0b exp=1", m_issue); end
        tick();
        idle();
    endtask

`ifdef ISSUE_SB_STATS_EN
    task automatic test_stats();
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("[TB] FAIL stats_reset got=%0d exp=0", stall_cycles); end
        issue_write(5'd6, 3'd7);
        m_valid = 1'b1; m_rs = 5'd6; m_rs_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        idle();
        wb_clr = 1'b1; wb_clr_addr = 5'd6;
        tick();
        idle();
        n_checks++; if (stall_cycles !== 32'd4) begin n_fail++; $display("[TB] FAIL stats_stall got=%0d exp=4", stall_cycles); end
        m_valid = 1'b1; m_wen = 1'b1; m_rd = 5'd3; m_lat = 3'd1;
        s_valid = 1'b1; s_wen = 1'b1; s_rd = 5'd3;
        tick();
        idle();
        n_checks++; if (slave_block_cycles !== 32'd1) begin n_fail++; $display("[TB] FAIL stats_sblock got=%0d exp=1", slave_block_cycles); end
        flush = 1'b1;
        tick();
        idle();
        n_checks++; if (stall_cycles !== 32'd4)       begin n_fail++; $display("[TB] FAIL stats_flush_stall got=%0d exp=4", stall_cycles); end
        n_checks++; if (slave_block_cycles !== 32'd1) begin n_fail++; $display("[TB] FAIL stats_flush_sblock got=%0d exp=1", slave_block_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_issue();
        test_latency();
        test_pair();
        test_lat_inf();
        test_freeze_flush();
        test_r0_and_async_reset();
`ifdef ISSUE_SB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
